// File: rtl/delay_timer.sv
// Programmable delay timer: on a start_shifting rise, captures a 4-bit delay
// serially (MSB first), then counts (delay+1) units and holds done until ack.
module delay_timer #(
    parameter int unsigned CYCLES_PER_UNIT = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_shifting,
    input  logic       data,
    input  logic       ack,
    output logic [3:0] count,
    output logic       counting,
    output logic       done
);

    localparam int unsigned UW = (CYCLES_PER_UNIT > 1) ? $clog2(CYCLES_PER_UNIT) : 1;
    localparam logic [UW-1:0] UNIT_LAST = UW'(CYCLES_PER_UNIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_COUNT,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic            ss_q;
    logic [2:0]      delay_q, delay_d;
    logic [1:0]      bit_cnt_q, bit_cnt_d;
    logic [UW-1:0]   unit_q, unit_d;
    logic [3:0]      count_q, count_d;
    logic            trigger;

    assign trigger = start_shifting & ~ss_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            ss_q      <= 1'b0;
            delay_q   <= '0;
            bit_cnt_q <= '0;
            unit_q    <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            ss_q      <= start_shifting;
            delay_q   <= delay_d;
            bit_cnt_q <= bit_cnt_d;
            unit_q    <= unit_d;
            count_q   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        delay_d   = delay_q;
        bit_cnt_d = bit_cnt_q;
        unit_d    = unit_q;
        count_d   = count_q;
        unique case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    delay_d   = {2'b00, data};
                    bit_cnt_d = 2'd1;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Only the first three bits are held; the 4th goes straight into count.
                delay_d   = {delay_q[1:0], data};
                bit_cnt_d = bit_cnt_q + 2'd1;
                if (bit_cnt_q == 2'd3) begin
                    count_d = {delay_q, data};
                    unit_d  = '0;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                unit_d = unit_q + UW'(1);
                if (unit_q == UNIT_LAST) begin
                    unit_d = '0;
                    if (count_q == 4'd0) begin
                        state_d = S_DONE;
                    end else begin
                        count_d = count_q - 4'd1;
                    end
                end
            end
            S_DONE: begin
                if (ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign counting = (state_q == S_COUNT);
    assign done     = (state_q == S_DONE);
    assign count    = counting ? count_q : 4'd0;

endmodule
